// File: rtl/mw_writeback_stage.sv
// -----------------------------------------------------------------------------
// mw_writeback_stage
//   M/W pipeline register and writeback datapath of the 5-stage MIPS core.
//   Latches the M-stage result, extends load data, selects the write-back
//   value, and drives the register-file write port plus the W-stage
//   forwarding bus. Also counts retired instructions and flags misaligned
//   loads with a sticky error bit.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   m_valid           M stage holds a real instruction (0 = bubble)
//   m_pc, m_a3, m_we  PC, destination register and write request from M
//   m_wd_sel          0=ALU, 1=MEM, 2=PC+8, 3=ALU
//   m_ld_type         0=LW, 1=LBU, 2=LB, 3=LHU, 4=LH, others=LW
//   m_alu_res         ALU result; bits [1:0] are the load byte offset
//   m_mem_rdata       aligned word read from data memory
//   w_a3, w_wd, w_we  register-file write port
//   w_pc              PC of the W-stage instruction (write trace)
//   w_fwd_valid       forwarding bus valid (write to a non-zero register)
//   w_valid           W holds a real instruction
//   w_err             sticky misaligned-load flag
//   w_retired         retired-instruction counter (wraps)
//
// Transfer semantics: there is no ready/stall. Whatever M presents on a
// posedge with m_valid=1 is accepted and appears on the W outputs after that
// edge; m_valid=0 inserts a bubble.
// -----------------------------------------------------------------------------
module mw_writeback_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_valid,
  input  logic [31:0] m_pc,
  input  logic [4:0]  m_a3,
  input  logic        m_we,
  input  logic [1:0]  m_wd_sel,
  input  logic [2:0]  m_ld_type,
  input  logic [31:0] m_alu_res,
  input  logic [31:0] m_mem_rdata,
  output logic [4:0]  w_a3,
  output logic [31:0] w_wd,
  output logic        w_we,
  output logic [31:0] w_pc,
  output logic        w_fwd_valid,
  output logic        w_valid,
  output logic        w_err,
  output logic [31:0] w_retired
);

  localparam logic [1:0] SEL_MEM = 2'd1;
  localparam logic [1:0] SEL_PC8 = 2'd2;

  localparam logic [2:0] LD_LBU = 3'd1;
  localparam logic [2:0] LD_LB  = 3'd2;
  localparam logic [2:0] LD_LHU = 3'd3;
  localparam logic [2:0] LD_LH  = 3'd4;

  logic        valid_q;
  logic [31:0] pc_q;
  logic [4:0]  a3_q;
  logic        we_q;
  logic [1:0]  wd_sel_q;
  logic [2:0]  ld_type_q;
  logic [31:0] alu_q;
  logic [31:0] mem_q;
  logic        err_q;
  logic [31:0] retired_q;

  logic [1:0]  off;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;
  logic        misaligned;
  logic [31:0] wd;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      pc_q      <= RESET_PC;
      a3_q      <= 5'd0;
      we_q      <= 1'b0;
      wd_sel_q  <= 2'd0;
      ld_type_q <= 3'd0;
      alu_q     <= 32'd0;
      mem_q     <= 32'd0;
      err_q     <= 1'b0;
      retired_q <= 32'd0;
    end else begin
      valid_q   <= m_valid;
      pc_q      <= m_pc;
      // Bubbles carry no destination so nothing downstream can match on them.
      a3_q      <= m_valid ? m_a3 : 5'd0;
      we_q      <= m_valid & m_we;
      wd_sel_q  <= m_wd_sel;
      ld_type_q <= m_ld_type;
      alu_q     <= m_alu_res;
      mem_q     <= m_mem_rdata;
      // The instruction currently in W retires on this edge.
      if (valid_q) retired_q <= retired_q + 32'd1;
      if (misaligned) err_q <= 1'b1;
    end
  end

  always_comb begin
    off = alu_q[1:0];

    byte_sel = mem_q[7:0];
    case (off)
      2'd0: byte_sel = mem_q[7:0];
      2'd1: byte_sel = mem_q[15:8];
      2'd2: byte_sel = mem_q[23:16];
      2'd3: byte_sel = mem_q[31:24];
      default: byte_sel = mem_q[7:0];
    endcase

    half_sel = off[1] ? mem_q[31:16] : mem_q[15:0];

    case (ld_type_q)
      LD_LBU:  load_ext = {24'd0, byte_sel};
      LD_LB:   load_ext = {{24{byte_sel[7]}}, byte_sel};
      LD_LHU:  load_ext = {16'd0, half_sel};
      LD_LH:   load_ext = {{16{half_sel[15]}}, half_sel};
      default: load_ext = mem_q;
    endcase

    // Halfword loads need even offsets; word loads (including the unused
    // ld_type codes, which behave as LW) need offset 0.
    misaligned = 1'b0;
    if (valid_q && wd_sel_q == SEL_MEM) begin
      case (ld_type_q)
        LD_LBU, LD_LB: misaligned = 1'b0;
        LD_LHU, LD_LH: misaligned = off[0];
        default:       misaligned = (off != 2'd0);
      endcase
    end

    case (wd_sel_q)
      SEL_MEM: wd = load_ext;
      SEL_PC8: wd = pc_q + 32'd8;
      default: wd = alu_q;
    endcase
  end

  assign w_a3        = a3_q;
  assign w_wd        = wd;
  assign w_we        = valid_q & we_q & ~misaligned;
  assign w_pc        = pc_q;
  assign w_fwd_valid = w_we & (a3_q != 5'd0);
  assign w_valid     = valid_q;
  assign w_err       = err_q;
  assign w_retired   = retired_q;

endmodule

// File: tb/tb_mw_writeback_stage.sv
module tb_mw_writeback_stage;

  logic        clk;
  logic        reset;
  logic        m_valid;
  logic [31:0] m_pc;
  logic [4:0]  m_a3;
  logic        m_we;
  logic [1:0]  m_wd_sel;
  logic [2:0]  m_ld_type;
  logic [31:0] m_alu_res;
  logic [31:0] m_mem_rdata;
  logic [4:0]  w_a3;
  logic [31:0] w_wd;
  logic        w_we;
  logic [31:0] w_pc;
  logic        w_fwd_valid;
  logic        w_valid;
  logic        w_err;
  logic [31:0] w_retired;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: what the W outputs should show after the last edge.
  logic        exp_valid;
  logic [31:0] exp_pc;
  logic [4:0]  exp_a3;
  logic        exp_we;
  logic [31:0] exp_wd;
  logic        exp_fwd;
  logic        exp_mis;
  logic        exp_err;
  logic [31:0] exp_retired;

  mw_writeback_stage dut (
    .clk(clk), .reset(reset), .m_valid(m_valid), .m_pc(m_pc), .m_a3(m_a3),
    .m_we(m_we), .m_wd_sel(m_wd_sel), .m_ld_type(m_ld_type),
    .m_alu_res(m_alu_res), .m_mem_rdata(m_mem_rdata), .w_a3(w_a3),
    .w_wd(w_wd), .w_we(w_we), .w_pc(w_pc), .w_fwd_valid(w_fwd_valid),
    .w_valid(w_valid), .w_err(w_err), .w_retired(w_retired)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Load result computed from the instruction semantics: shift the addressed
  // unit down to bit 0, then zero- or sign-extend it.
  function automatic logic [31:0] model_wd(input logic [1:0] sel, input logic [2:0] ld,
                                           input logic [31:0] alu, input logic [31:0] mem,
                                           input logic [31:0] pc);
    logic [31:0] shifted;
    logic [31:0] b;
    logic [31:0] h;
    if (sel == 2'd2) return pc + 32'd8;
    if (sel != 2'd1) return alu;
    shifted = mem >> (8 * alu[1:0]);
    b = shifted & 32'hFF;
    h = alu[1] ? (mem >> 16) : (mem & 32'hFFFF);
    case (ld)
      3'd1: return b;
      3'd2: return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      3'd3: return h;
      3'd4: return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      default: return mem;
    endcase
  endfunction

  function automatic logic model_mis(input logic v, input logic [1:0] sel,
                                     input logic [2:0] ld, input logic [31:0] alu);
    if (!v || sel != 2'd1) return 1'b0;
    if (ld == 3'd1 || ld == 3'd2) return 1'b0;
    if (ld == 3'd3 || ld == 3'd4) return (alu % 2) != 0;
    return (alu % 4) != 0;
  endfunction

  // Driver: present one M-stage beat, let it cross the edge, update the model.
  task automatic apply(input logic rst, input logic v, input logic [31:0] pc,
                       input logic [4:0] a3, input logic we, input logic [1:0] sel,
                       input logic [2:0] ld, input logic [31:0] alu, input logic [31:0] mem);
    @(negedge clk);
    reset = rst; m_valid = v; m_pc = pc; m_a3 = a3; m_we = we;
    m_wd_sel = sel; m_ld_type = ld; m_alu_res = alu; m_mem_rdata = mem;
    @(posedge clk);
    #1;
    if (rst) begin
      exp_retired = 32'd0;
      exp_err = 1'b0;
      exp_valid = 1'b0; exp_pc = 32'h0000_3000; exp_a3 = 5'd0;
      exp_we = 1'b0; exp_wd = 32'd0; exp_fwd = 1'b0; exp_mis = 1'b0;
    end else begin
      if (exp_valid) exp_retired = exp_retired + 32'd1;
      if (exp_mis) exp_err = 1'b1;
      exp_valid = v;
      exp_pc = pc;
      exp_a3 = v ? a3 : 5'd0;
      exp_mis = model_mis(v, sel, ld, alu);
      exp_we = v && we && !exp_mis;
      exp_wd = model_wd(sel, ld, alu, mem, pc);
      exp_fwd = exp_we && (exp_a3 != 5'd0);
    end
  endtask

  task automatic bubble();
    apply(1'b0, 1'b0, 32'd0, 5'd0, 1'b0, 2'd0, 3'd0, 32'd0, 32'd0);
  endtask

  task automatic test_reset();
    apply(1'b1, 1'b1, 32'h1234_5678, 5'd9, 1'b1, 2'd0, 3'd0, 32'hDEAD, 32'd0);
    apply(1'b1, 1'b1, 32'h1234_5678, 5'd9, 1'b1, 2'd0, 3'd0, 32'hDEAD, 32'd0);
    n_tests++;
    if (w_pc !== 32'h0000_3000 || w_we !== 1'b0 || w_retired !== 32'd0 || w_err !== 1'b0 ||
        w_valid !== 1'b0 || w_a3 !== 5'd0 || w_wd !== 32'd0 || w_fwd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: pc=%h we=%b ret=%0d err=%b valid=%b a3=%0d wd=%h fwd=%b (want pc=00003000 all else 0)",
               w_pc, w_we, w_retired, w_err, w_valid, w_a3, w_wd, w_fwd_valid);
    end
  endtask

  task automatic test_alu();
    apply(1'b0, 1'b1, 32'h3000, 5'd8, 1'b1, 2'd0, 3'd0, 32'h1234, 32'hFFFF_FFFF);
    n_tests++;
    if (w_we !== 1'b1 || w_a3 !== 5'd8 || w_wd !== 32'h1234 || w_fwd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL alu: we=%b a3=%0d wd=%h fwd=%b (want 1 8 00001234 1)", w_we, w_a3, w_wd, w_fwd_valid);
    end
    // Reserved select behaves as ALU.
    apply(1'b0, 1'b1, 32'h3004, 5'd3, 1'b1, 2'd3, 3'd0, 32'hCAFE_0001, 32'h0);
    n_tests++;
    if (w_wd !== 32'hCAFE_0001) begin
      n_fail++;
      $display("FAIL alu_sel3: wd=%h want cafe0001", w_wd);
    end
  endtask

  task automatic test_load_ext();
    logic [2:0]  ld_t[4]  = '{3'd2, 3'd2, 3'd3, 3'd4};
    logic [31:0] alu_t[4] = '{32'h1001, 32'h1003, 32'h1002, 32'h1000};
    logic [31:0] exp_t[4] = '{32'h0000_007F, 32'hFFFF_FF80, 32'h0000_80FF, 32'h0000_7F01};
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b1, 32'h3100 + 32'(i * 4), 5'd4, 1'b1, 2'd1, ld_t[i], alu_t[i], 32'h80FF_7F01);
      n_tests++;
      if (w_wd !== exp_t[i] || w_we !== 1'b1) begin
        n_fail++;
        $display("FAIL load_ext[%0d]: wd=%h we=%b want wd=%h we=1", i, w_wd, w_we, exp_t[i]);
      end
    end
  endtask

  task automatic test_jal();
    apply(1'b0, 1'b1, 32'h3010, 5'd31, 1'b1, 2'd2, 3'd0, 32'h0, 32'h0);
    n_tests++;
    if (w_wd !== 32'h3018 || w_we !== 1'b1 || w_a3 !== 5'd31 || w_pc !== 32'h3010) begin
      n_fail++;
      $display("FAIL jal: wd=%h we=%b a3=%0d pc=%h (want 00003018 1 31 00003010)", w_wd, w_we, w_a3, w_pc);
    end
    // PC+8 wraps modulo 2^32.
    apply(1'b0, 1'b1, 32'hFFFF_FFFC, 5'd31, 1'b1, 2'd2, 3'd0, 32'h0, 32'h0);
    n_tests++;
    if (w_wd !== 32'h0000_0004) begin
      n_fail++;
      $display("FAIL jal_wrap: wd=%h want 00000004", w_wd);
    end
  endtask

  task automatic test_misaligned();
    n_tests++;
    if (w_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_before: err=%b want 0", w_err);
    end
    apply(1'b0, 1'b1, 32'h3200, 5'd5, 1'b1, 2'd1, 3'd0, 32'h1002, 32'h1111_2222);
    n_tests++;
    if (w_we !== 1'b0 || w_err !== 1'b0 || w_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL misaligned_lw: we=%b err=%b valid=%b want 0 0 1", w_we, w_err, w_valid);
    end
    bubble();
    n_tests++;
    if (w_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_set: err=%b want 1", w_err);
    end
    // LH at odd offset is also misaligned; err stays set.
    apply(1'b0, 1'b1, 32'h3204, 5'd6, 1'b1, 2'd1, 3'd4, 32'h1001, 32'h0);
    n_tests++;
    if (w_we !== 1'b0 || w_err !== 1'b1) begin
      n_fail++;
      $display("FAIL misaligned_lh: we=%b err=%b want 0 1", w_we, w_err);
    end
  endtask

  task automatic test_zero_reg();
    apply(1'b0, 1'b1, 32'h3300, 5'd0, 1'b1, 2'd0, 3'd0, 32'h55, 32'h0);
    n_tests++;
    if (w_we !== 1'b1 || w_fwd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_reg: we=%b fwd=%b want 1 0", w_we, w_fwd_valid);
    end
  endtask

  task automatic test_retire_count();
    apply(1'b1, 1'b0, 32'h0, 5'd0, 1'b0, 2'd0, 3'd0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++)
      apply(1'b0, 1'b1, 32'h3400 + 32'(4 * i), 5'd1, 1'b1, 2'd0, 3'd0, 32'(i), 32'h0);
    bubble();
    n_tests++;
    if (w_retired !== 32'd3) begin
      n_fail++;
      $display("FAIL retire3: retired=%0d want 3", w_retired);
    end
    bubble();
    n_tests++;
    if (w_retired !== 32'd3 || w_valid !== 1'b0 || w_we !== 1'b0 || w_a3 !== 5'd0) begin
      n_fail++;
      $display("FAIL bubble_hold: retired=%0d valid=%b we=%b a3=%0d want 3 0 0 0", w_retired, w_valid, w_we, w_a3);
    end
  endtask

  task automatic test_counter_wrap();
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    exp_retired = 32'hFFFF_FFFF;
    n_tests++;
    if (w_retired !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL preload: retired=%h want ffffffff", w_retired);
    end
    apply(1'b0, 1'b1, 32'h3500, 5'd2, 1'b1, 2'd0, 3'd0, 32'h7, 32'h0);
    bubble();
    n_tests++;
    if (w_retired !== 32'd0) begin
      n_fail++;
      $display("FAIL wrap: retired=%h want 0", w_retired);
    end
  endtask

  task automatic test_reset_midstream();
    apply(1'b0, 1'b1, 32'h3600, 5'd7, 1'b1, 2'd0, 3'd0, 32'h99, 32'h0);
    apply(1'b1, 1'b1, 32'h3604, 5'd7, 1'b1, 2'd0, 3'd0, 32'h98, 32'h0);
    n_tests++;
    if (w_we !== 1'b0 || w_valid !== 1'b0 || w_retired !== 32'd0 || w_pc !== 32'h3000 || w_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: we=%b valid=%b ret=%0d pc=%h err=%b want 0 0 0 00003000 0",
               w_we, w_valid, w_retired, w_pc, w_err);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      apply(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), $urandom(),
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            3'($urandom_range(0, 7)), $urandom(), $urandom());
      n_tests++;
      if (w_valid !== exp_valid || w_a3 !== exp_a3 || w_we !== exp_we || w_fwd_valid !== exp_fwd ||
          w_err !== exp_err || w_retired !== exp_retired ||
          (exp_valid && (w_wd !== exp_wd || w_pc !== exp_pc))) begin
        n_fail++;
        $display("FAIL random[%0d]: valid=%b/%b a3=%0d/%0d we=%b/%b fwd=%b/%b err=%b/%b ret=%0d/%0d wd=%h/%h pc=%h/%h (got/want)",
                 i, w_valid, exp_valid, w_a3, exp_a3, w_we, exp_we, w_fwd_valid, exp_fwd,
                 w_err, exp_err, w_retired, exp_retired, w_wd, exp_wd, w_pc, exp_pc);
      end
    end
  endtask

  initial begin
    reset = 1'b1; m_valid = 1'b0; m_pc = 32'd0; m_a3 = 5'd0; m_we = 1'b0;
    m_wd_sel = 2'd0; m_ld_type = 3'd0; m_alu_res = 32'd0; m_mem_rdata = 32'd0;
    exp_valid = 1'b0; exp_pc = 32'h3000; exp_a3 = 5'd0; exp_we = 1'b0; exp_wd = 32'd0;
    exp_fwd = 1'b0; exp_mis = 1'b0; exp_err = 1'b0; exp_retired = 32'd0;
    test_reset();
    test_alu();
    test_load_ext();
    test_jal();
    test_misaligned();
    test_zero_reg();
    test_retire_count();
    test_counter_wrap();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
